// File: rtl/link_peer.sv
// link_peer -- byte-wide peer for the DMG serial link.
//
// Exchanges one byte per transfer over a SCK/SI/SO link, MSB first. In slave
// mode the DMG supplies SCK and the peer follows its synchronized edges. In
// master mode the peer generates SCK itself at CLK_DIV clk cycles per
// half-period. Data goes out on each SCK falling edge and is sampled on each
// rising edge.
//
// Ports
//   clk               system clock, rising edge
//   nreset            synchronous active-low reset
//   master            mode select (1 = peer drives SCK), sampled only in IDLE
//   sck_in, sin       link clock and DMG SO, asynchronous to clk
//   sck_out, sck_oe   generated SCK and its drive enable
//   sout              data to DMG SI
//   tx_data/tx_valid/tx_ready   byte-to-send handshake
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   busy              high whenever a transfer is pending or running
module link_peer #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       master,
    input  logic       sck_in,
    input  logic       sin,
    output logic       sck_out,
    output logic       sck_oe,
    output logic       sout,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic       sck_meta, sck_sync, sck_prev;
    logic       sin_meta, sin_sync;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic       mode;
    logic       got8;        // all 8 bits sampled; master waits out the last high half
    logic [7:0] gen_cnt;

    logic eff_mode, slv_fall, slv_rise;
    logic gen_tick, gen_rise, gen_fall, gen_end;
    logic sh_fall, sh_rise, take;

    // Before a transfer latches the mode, the live master pin decides whether
    // slave edges count.
    assign eff_mode = (state == IDLE) ? master : mode;
    assign slv_fall = !eff_mode &&  sck_prev && !sck_sync;
    assign slv_rise = !eff_mode && !sck_prev &&  sck_sync;

    assign gen_tick = mode && (state == SHIFT) && (gen_cnt == 8'(CLK_DIV - 1));
    assign gen_rise = gen_tick && !sck_out;
    assign gen_fall = gen_tick &&  sck_out && !got8;
    assign gen_end  = gen_tick &&  sck_out &&  got8;

    assign sh_fall = (state == SHIFT) && (mode ? gen_fall : slv_fall);
    assign sh_rise = (state == SHIFT) && (mode ? gen_rise : slv_rise);

    // A slave falling edge in IDLE starts the transfer with whatever shreg
    // holds, so a byte offered in that same cycle must wait.
    assign tx_ready = (state == IDLE) && !slv_fall;
    assign take     = tx_valid && tx_ready;
    assign busy     = (state != IDLE);
    assign sck_oe   = busy ? mode : master;

    // NOTE: every variable written here gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (slv_fall)                state_nxt = SHIFT;
                   else if (take)               state_nxt = ARMED;
            ARMED: if (mode || slv_fall)        state_nxt = SHIFT;
            SHIFT: if (mode ? gen_end : (sh_rise && bitcnt == 3'd7))
                                                state_nxt = DONE;
            DONE:                               state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sck_meta <= 1'b1;
            sck_sync <= 1'b1;
            sck_prev <= 1'b1;
            sin_meta <= 1'b1;
            sin_sync <= 1'b1;
            shreg    <= 8'hFF;
            bitcnt   <= 3'd0;
            mode     <= 1'b0;
            got8     <= 1'b0;
            gen_cnt  <= 8'd0;
            sout     <= 1'b1;
            sck_out  <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            sck_meta <= sck_in;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            sin_meta <= sin;
            sin_sync <= sin_meta;
            rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (slv_fall) begin
                        mode   <= 1'b0;
                        bitcnt <= 3'd0;
                        got8   <= 1'b0;
                        sout   <= shreg[7];
                    end else if (take) begin
                        shreg <= tx_data;
                        mode  <= master;
                    end
                end
                ARMED: begin
                    // Entering SHIFT in master mode is itself the first
                    // falling edge of the generated clock.
                    if (mode || slv_fall) begin
                        bitcnt <= 3'd0;
                        got8   <= 1'b0;
                        sout   <= shreg[7];
                    end
                    if (mode) begin
                        sck_out <= 1'b0;
                        gen_cnt <= 8'd0;
                    end
                end
                SHIFT: begin
                    if (mode) begin
                        gen_cnt <= gen_tick ? 8'd0 : gen_cnt + 8'd1;
                        if (gen_rise || gen_fall) sck_out <= ~sck_out;
                    end
                    if (sh_fall) sout <= shreg[7];
                    if (sh_rise) begin
                        shreg  <= {shreg[6:0], sin_sync};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) got8 <= 1'b1;
                    end
                end
                DONE: begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                    shreg    <= 8'hFF;
                    sck_out  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_link_peer.sv
// Bench for link_peer: slave exchanges, unloaded slave, master mode timing,
// byte offered on the first falling edge, mid-transfer reset and a mode
// change while busy. Received bytes are checked through a scoreboard queue.
module tb_link_peer;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       master = 1'b0;
    logic       sck_in = 1'b1;
    logic       sin = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sck_out, sck_oe, sout, tx_ready, rx_valid, busy;
    logic [7:0] rx_data;

    int         n_checks = 0;
    int         n_errors = 0;
    int         rx_cnt = 0;
    logic       rx_prev = 1'b0;
    logic [7:0] exp_q[$];

    link_peer #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .master   (master),
        .sck_in   (sck_in),
        .sin      (sin),
        .sck_out  (sck_out),
        .sck_oe   (sck_oe),
        .sout     (sout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // Scoreboard consumer: every rx_valid pulse must match the oldest
    // expected byte and last exactly one cycle.
    always @(negedge clk) begin
        logic [7:0] w;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            check("rx_single", 32'(rx_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                w = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(w));
            end
        end
        rx_prev = rx_valid;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d);
        bit ok = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("load_ok", 32'(ok), 32'd1);
    endtask

    // DMG-side clocking of bits first..last-1: falling edge with new SO
    // data, check the peer's SI bit, then rising edge.
    task automatic dmg_xfer(input logic [7:0] dout, input logic [7:0] exp_sout,
                            input int first, input int last);
        for (int i = first; i < last; i++) begin
            sck_in = 1'b0;
            sin    = dout[7-i];
            clks(6);
            @(negedge clk);
            check($sformatf("sout_b%0d", i), 32'(sout), 32'(exp_sout[7-i]));
            @(posedge clk);
            #1;
            sck_in = 1'b1;
            clks(6);
        end
    endtask

    initial begin
        int  busy_n, rises, low_run, high_run;
        logic sck_p, rise, fall;
        bit  done, hs;
        logic [7:0] m_byte;

        // ---- reset state
        nreset = 1'b0;
        clks(3);
        @(negedge clk);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_sout",     32'(sout),     32'd1);
        check("rst_sck_out",  32'(sck_out),  32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'h00);
        check("rst_sck_oe",   32'(sck_oe),   32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        master = 1'b1;
        @(negedge clk);
        check("idle_sck_oe_m", 32'(sck_oe), 32'd1);
        @(posedge clk);
        #1;
        master = 1'b0;
        clks(2);

        // ---- slave exchange 0xA5 out, 0x3C in
        load_byte(8'hA5);
        @(negedge clk);
        check("armed_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h3C);
        dmg_xfer(8'h3C, 8'hA5, 0, 8);
        @(negedge clk);
        check("x1_idle", 32'(busy), 32'd0);
        check("x1_rx_cnt", 32'(rx_cnt), 32'd1);
        @(posedge clk);
        #1;

        // ---- unloaded slave: sends 0xFF
        exp_q.push_back(8'h81);
        dmg_xfer(8'h81, 8'hFF, 0, 8);
        @(negedge clk);
        check("x2_rx_cnt", 32'(rx_cnt), 32'd2);
        @(posedge clk);
        #1;

        // ---- master mode, CLK_DIV=4, sin tied low
        master = 1'b1;
        sin    = 1'b0;
        m_byte = 8'h5A;
        exp_q.push_back(8'h00);
        load_byte(m_byte);
        busy_n = 0; rises = 0; low_run = 0; high_run = 0;
        sck_p = 1'b1; done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            busy_n++;
            rise = sck_out && !sck_p;
            fall = !sck_out && sck_p;
            if (rise) begin
                check("m_low_len", 32'(low_run), 32'd4);
                if (rises < 8) check($sformatf("m_sout_b%0d", rises), 32'(sout), 32'(m_byte[7-rises]));
                rises++;
            end
            if (fall && rises > 0) check("m_high_len", 32'(high_run), 32'd4);
            if (sck_out) begin
                if (rise) high_run = 0;
                high_run++;
            end else begin
                if (fall) low_run = 0;
                low_run++;
            end
            if (c == 2) check("m_sck_oe", 32'(sck_oe), 32'd1);
            sck_p = sck_out;
        end
        check("m_done", 32'(done), 32'd1);
        check("m_rises", 32'(rises), 32'd8);
        check("m_busy_len", 32'(busy_n >= 66 && busy_n <= 68), 32'd1);
        @(posedge clk);
        #1;
        master = 1'b0;
        sin    = 1'b1;
        clks(2);
        check("m_rx_cnt", 32'(rx_cnt), 32'd3);

        // ---- byte offered in the cycle of the first slave falling edge
        exp_q.push_back(8'h99);
        sck_in = 1'b0;
        sin    = 1'b1;
        clks(2);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        check("sim_tx_ready", 32'(tx_ready), 32'd0);
        check("sim_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        clks(3);
        @(negedge clk);
        check("sim_sout_b0", 32'(sout), 32'd1);
        check("sim_tx_ready_shift", 32'(tx_ready), 32'd0);
        @(posedge clk);
        #1;
        sck_in = 1'b1;
        clks(6);
        dmg_xfer(8'h99, 8'hFF, 1, 7);
        sck_in = 1'b0;
        sin    = 1'b1;
        clks(6);
        @(negedge clk);
        check("sim_sout_b7", 32'(sout), 32'd1);
        @(posedge clk);
        #1;
        sck_in = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_ready) begin
                check("hs_after_done", 32'(rx_valid), 32'd1);
                hs = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("hs_seen", 32'(hs), 32'd1);
        @(negedge clk);
        check("hs_armed", 32'(busy), 32'd1);
        @(posedge clk);
        #1;

        // ---- reset after 4 bits of the armed 0x77 transfer
        dmg_xfer(8'h12, 8'h77, 0, 4);
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_sout", 32'(sout), 32'd1);
        check("ab_tx_ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        clks(20);
        check("ab_no_rx", 32'(rx_cnt), 32'd4);
        load_byte(8'hA5);
        exp_q.push_back(8'h3C);
        dmg_xfer(8'h3C, 8'hA5, 0, 8);
        @(negedge clk);
        check("ab_rx_cnt", 32'(rx_cnt), 32'd5);
        @(posedge clk);
        #1;

        // ---- master toggles mid-transfer: stays in slave mode
        load_byte(8'hC3);
        exp_q.push_back(8'h5E);
        dmg_xfer(8'h5E, 8'hC3, 0, 3);
        master = 1'b1;
        @(negedge clk);
        check("mc_sck_oe", 32'(sck_oe), 32'd0);
        check("mc_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        dmg_xfer(8'h5E, 8'hC3, 3, 5);
        @(negedge clk);
        check("mc_sck_out", 32'(sck_out), 32'd1);
        check("mc_sck_oe2", 32'(sck_oe), 32'd0);
        @(posedge clk);
        #1;
        dmg_xfer(8'h5E, 8'hC3, 5, 8);
        @(negedge clk);
        check("mc_idle", 32'(busy), 32'd0);
        check("mc_sck_oe_idle", 32'(sck_oe), 32'd1);
        @(posedge clk);
        #1;
        master = 1'b0;
        clks(5);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("rx_total", 32'(rx_cnt), 32'd6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
